snr_window_sequencer: RTL and testbench
=======================================

// Module: snr_window_sequencer
// PURPOSE
//   Sequences the PPG SNR measurement over fixed windows of WINDOW = 2**WIN_LOG2 samples.
//   Per accepted sample: forms noise = data_out - smoothed_signal (signed).
//   Accumulates sum(smoothed^2) as signal energy and sum(noise^2) as noise energy.
//   Presents both sums to the downstream SNR/ratio stage with a valid/ready handshake.
//   Sits between the moving-average filter output and the SNR divider; owns window
//   timing, restart and abort.
// PARAMETERS
//   DATA_WIDTH  16  width of data_out / smoothed_signal (unsigned samples)
//   WIN_LOG2     6  log2 of window length (WINDOW = 64); legal range 1..12
//   ACC_W   (localparam) 2*DATA_WIDTH+WIN_LOG2 = 38, accumulator/result width
// PORTS
//   clk              in   1           single clock, rising edge
//   reset_n          in   1           asynchronous, active-low reset
//   start            in   1           pulse: begin a window (honoured only in IDLE)
//   continuous       in   1           1 = auto-restart a new window after each handshake
//   abort            in   1           synchronous abort, any state -> IDLE
//   sample_valid     in   1           data_out/smoothed_signal valid this cycle
//   data_out         in   DATA_WIDTH  raw PPG sample
//   smoothed_signal  in   DATA_WIDTH  filtered sample aligned with data_out
//   busy             out  1           1 in ACCUM or HOLD
//   sample_count     out  WIN_LOG2+1  samples accepted in current window
//   signal_energy    out  ACC_W       sum of smoothed_signal^2 over window
//   noise_energy     out  ACC_W       sum of (data_out-smoothed_signal)^2 over window
//   result_valid     out  1           energies valid and held stable
//   result_ready     in   1           downstream accepts result
//   sample_lost      out  1           sticky: sample_valid seen while in HOLD
// BEHAVIOUR
//   Reset: state=IDLE, all outputs 0 (busy, sample_count, energies, result_valid, sample_lost).
//   Arithmetic:
//     noise is DATA_WIDTH+1 signed; noise^2 and smoothed^2 are 2*DATA_WIDTH unsigned.
//     Accumulators are ACC_W wide and cannot overflow for a full window.
//   IDLE:
//     start=1 -> ACCUM; clear energies, sample_count and sample_lost.
//     sample_valid is ignored.
//   ACCUM:
//     Each cycle with sample_valid=1: both accumulators add the new term and
//     sample_count increments, registered on that edge.
//     The WINDOW-th accepted sample -> HOLD; result_valid=1 on the next cycle (latency 1).
//     sample_valid=0 cycles stall the window with no timeout.
//   HOLD:
//     Energies and sample_count are frozen; result_valid=1.
//     result_valid && result_ready -> result_valid=0 on the next cycle.
//       continuous=1: -> ACCUM with accumulators/count cleared in that same edge.
//       continuous=0: -> IDLE; energies stay readable.
//     sample_valid in HOLD: sample dropped, sample_lost<=1.
//     A HOLD-to-ACCUM edge coinciding with sample_valid also drops that sample and sets sample_lost.
//     sample_lost clears only on an honoured start or on reset.
//   abort: wins over every other input, including start and result_ready in the same cycle.
//     -> IDLE, result_valid=0, sample_count=0; energies retain their values.
//   start outside IDLE: ignored.
//   reset_n low mid-window: immediate return to reset values; no partial result.
// STRUCTURE
//   Shared package snr_pkg: state encodings IDLE=2'd0, ACCUM=2'd1, HOLD=2'd2, and the ACC_W formula.
//   One sub-module, snr_energy_acc: squarer+accumulator pair with clear/enable.
//     The FSM, counter and handshake stay in this top-level module.
// TESTING (WIN_LOG2=2, WINDOW=4, DATA_WIDTH=16)
//   1. start; 4x (data=10, smooth=8) -> signal_energy=256, noise_energy=16,
//      result_valid 1 cycle after 4th sample.
//   2. 4x (data=5, smooth=8), negative noise -> noise_energy=36, signal_energy=256.
//   3. 4x (data=0, smooth=65535) -> signal_energy=noise_energy=17179344900, no overflow.
//   4. result_ready=0 for 10 cycles with sample_valid=1 -> outputs stable, sample_lost=1;
//      then ready=1 with continuous=1 -> new window, count=0.
//   5. abort after 2 samples with start=1 in the same cycle -> IDLE, count=0,
//      result_valid never asserts.
//   6. reset_n=0 mid-ACCUM -> all outputs 0 asynchronously; subsequent start gives a clean window.

Source files
------------

// File: rtl/snr_pkg.sv
`default_nettype none
// ============================================================================
// snr_pkg : state encodings and accumulator width helper for SNR sequencing
// Rev 1.0
// ============================================================================
package snr_pkg;

   typedef logic [1:0] snr_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ACCUM = 2'd1;
   localparam logic [1:0] ST_HOLD  = 2'd2;

   // A full window of squared samples needs 2*DATA_WIDTH + WIN_LOG2 bits.
   function automatic int calc_acc_w(input int data_width, input int win_log2);
      return 2 * data_width + win_log2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/snr_energy_acc.sv
`default_nettype none
// ============================================================================
// snr_energy_acc : squarer + accumulator pair for signal and noise energy
// Rev 1.0
// ============================================================================
module snr_energy_acc
   import snr_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_W      = 38
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [DATA_WIDTH-1:0] smooth_in,
   output logic [ACC_W-1:0]      signal_energy,
   output logic [ACC_W-1:0]      noise_energy
);

   localparam int PAD_W = ACC_W - 2 * DATA_WIDTH;

   logic [DATA_WIDTH-1:0]   noise_mag;
   logic [2*DATA_WIDTH-1:0] signal_sq;
   logic [2*DATA_WIDTH-1:0] noise_sq;

   // The squared signed difference only needs its magnitude, which always fits DATA_WIDTH bits.
   always_comb begin
      noise_mag = (data_in >= smooth_in) ? (data_in - smooth_in) : (smooth_in - data_in);
      signal_sq = {{DATA_WIDTH{1'b0}}, smooth_in} * {{DATA_WIDTH{1'b0}}, smooth_in};
      noise_sq  = {{DATA_WIDTH{1'b0}}, noise_mag} * {{DATA_WIDTH{1'b0}}, noise_mag};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         signal_energy <= '0;
         noise_energy  <= '0;
      end else if (clear) begin
         signal_energy <= '0;
         noise_energy  <= '0;
      end else if (enable) begin
         signal_energy <= signal_energy + {{PAD_W{1'b0}}, signal_sq};
         noise_energy  <= noise_energy  + {{PAD_W{1'b0}}, noise_sq};
      end
   end

endmodule
`default_nettype wire

// File: rtl/snr_window_sequencer.sv
`default_nettype none
// ============================================================================
// snr_window_sequencer : windowed signal/noise energy accumulation with
// valid/ready result handoff, continuous restart and abort.   Rev 1.0
// ============================================================================
module snr_window_sequencer
   import snr_pkg::*;
#(
   parameter  int DATA_WIDTH = 16,
   parameter  int WIN_LOG2   = 6,
   localparam int ACC_W      = calc_acc_w(DATA_WIDTH, WIN_LOG2)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic                  continuous,
   input  logic                  abort,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] data_out,
   input  logic [DATA_WIDTH-1:0] smoothed_signal,
   output logic                  busy,
   output logic [WIN_LOG2:0]     sample_count,
   output logic [ACC_W-1:0]      signal_energy,
   output logic [ACC_W-1:0]      noise_energy,
   output logic                  result_valid,
   input  logic                  result_ready,
   output logic                  sample_lost
);

   localparam logic [WIN_LOG2:0] LAST_CNT = {1'b0, {WIN_LOG2{1'b1}}};
   localparam logic [WIN_LOG2:0] CNT_ONE  = {{WIN_LOG2{1'b0}}, 1'b1};

   snr_state_t state;
   logic       acc_clear;
   logic       acc_enable;

   // Clearing happens on the same edge that opens a new window.
   always_comb begin
      acc_clear  = 1'b0;
      acc_enable = 1'b0;
      if (!abort) begin
         acc_clear  = ((state == ST_IDLE) && start) ||
                      ((state == ST_HOLD) && result_ready && continuous);
         acc_enable = (state == ST_ACCUM) && sample_valid;
      end
   end

   assign busy = (state == ST_ACCUM) || (state == ST_HOLD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         sample_count <= '0;
         result_valid <= 1'b0;
         sample_lost  <= 1'b0;
      end else if (abort) begin
         state        <= ST_IDLE;
         sample_count <= '0;
         result_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state        <= ST_ACCUM;
                  sample_count <= '0;
                  sample_lost  <= 1'b0;
               end
            end
            ST_ACCUM: begin
               if (sample_valid) begin
                  sample_count <= sample_count + CNT_ONE;
                  if (sample_count == LAST_CNT) begin
                     state        <= ST_HOLD;
                     result_valid <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               // Samples arriving while the result is pending are dropped, including on the restart edge.
               if (sample_valid) begin
                  sample_lost <= 1'b1;
               end
               if (result_ready) begin
                  result_valid <= 1'b0;
                  if (continuous) begin
                     state        <= ST_ACCUM;
                     sample_count <= '0;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: begin
               state        <= ST_IDLE;
               result_valid <= 1'b0;
            end
         endcase
      end
   end

   snr_energy_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_W      (ACC_W)
   ) u_energy_acc (
      .clk           (clk),
      .reset_n       (reset_n),
      .clear         (acc_clear),
      .enable        (acc_enable),
      .data_in       (data_out),
      .smooth_in     (smoothed_signal),
      .signal_energy (signal_energy),
      .noise_energy  (noise_energy)
   );

endmodule
`default_nettype wire

// File: tb/tb_snr_window_sequencer.sv
`default_nettype none
// ============================================================================
// tb_snr_window_sequencer : directed + randomized bench with behavioural model
// Rev 1.0
// ============================================================================
module tb_snr_window_sequencer;

   localparam int DW     = 16;
   localparam int WL     = 2;
   localparam int WINDOW = 4;
   localparam int ACC_W  = 2 * DW + WL;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          start;
   logic          continuous;
   logic          abort;
   logic          sample_valid;
   logic [DW-1:0] data_out;
   logic [DW-1:0] smoothed_signal;
   logic          busy;
   logic [WL:0]   sample_count;
   logic [ACC_W-1:0] signal_energy;
   logic [ACC_W-1:0] noise_energy;
   logic          result_valid;
   logic          result_ready;
   logic          sample_lost;

   int n_tests = 0;
   int n_fail  = 0;
   bit cmp_en  = 1'b0;

   // Model: mode 0 = idle, 1 = collecting samples, 2 = waiting for handoff.
   int     m_mode;
   int     m_cnt;
   longint m_sig;
   longint m_noi;
   bit     m_lost;

   snr_window_sequencer #(
      .DATA_WIDTH (DW),
      .WIN_LOG2   (WL)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .continuous      (continuous),
      .abort           (abort),
      .sample_valid    (sample_valid),
      .data_out        (data_out),
      .smoothed_signal (smoothed_signal),
      .busy            (busy),
      .sample_count    (sample_count),
      .signal_energy   (signal_energy),
      .noise_energy    (noise_energy),
      .result_valid    (result_valid),
      .result_ready    (result_ready),
      .sample_lost     (sample_lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = 0;
      m_cnt  = 0;
      m_sig  = 0;
      m_noi  = 0;
      m_lost = 1'b0;
   endtask

   task automatic model_step();
      longint s;
      longint d;
      s = longint'(smoothed_signal);
      d = longint'(data_out) - s;
      if (!reset_n) begin
         model_reset();
      end else if (abort) begin
         m_mode = 0;
         m_cnt  = 0;
      end else if (m_mode == 0) begin
         if (start) begin
            m_mode = 1; m_cnt = 0; m_sig = 0; m_noi = 0; m_lost = 1'b0;
         end
      end else if (m_mode == 1) begin
         if (sample_valid) begin
            m_sig += s * s;
            m_noi += d * d;
            m_cnt++;
            if (m_cnt == WINDOW) m_mode = 2;
         end
      end else begin
         if (sample_valid) m_lost = 1'b1;
         if (result_ready) begin
            if (continuous) begin
               m_mode = 1; m_cnt = 0; m_sig = 0; m_noi = 0;
            end else begin
               m_mode = 0;
            end
         end
      end
   endtask

   // One clock: model consumes the inputs seen at the edge, then inputs may change.
   task automatic step();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic drive(input bit st, input bit ab, input bit sv,
                        input logic [DW-1:0] d, input logic [DW-1:0] s, input bit rdy);
      start           = st;
      abort           = ab;
      sample_valid    = sv;
      data_out        = d;
      smoothed_signal = s;
      result_ready    = rdy;
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy",          64'(busy),          64'(m_mode != 0));
         chk("sample_count",  64'(sample_count),  64'(m_cnt));
         chk("signal_energy", 64'(signal_energy), 64'(m_sig));
         chk("noise_energy",  64'(noise_energy),  64'(m_noi));
         chk("result_valid",  64'(result_valid),  64'(m_mode == 2));
         chk("sample_lost",   64'(sample_lost),   64'(m_lost));
      end
   end

   initial begin
      reset_n    = 1'b1;
      continuous = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      model_reset();
      #1 reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_busy",   64'(busy),          64'd0);
      chk("rst_count",  64'(sample_count),  64'd0);
      chk("rst_sig",    64'(signal_energy), 64'd0);
      chk("rst_noise",  64'(noise_energy),  64'd0);
      chk("rst_rv",     64'(result_valid),  64'd0);
      chk("rst_lost",   64'(sample_lost),   64'd0);
      step();
      step();
      reset_n = 1'b1;
      cmp_en  = 1'b1;
      step();

      // 1: positive noise, result one cycle after the last sample
      drive(1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 16'd10, 16'd8, 0); step();
         chk("t1_rv_latency", 64'(result_valid), 64'(i == 3));
      end
      chk("t1_sig",   64'(signal_energy), 64'd256);
      chk("t1_noise", 64'(noise_energy),  64'd16);
      drive(0, 0, 0, 0, 0, 1); step();
      chk("t1_idle_rv",   64'(result_valid),  64'd0);
      chk("t1_idle_keep", 64'(signal_energy), 64'd256);

      // 2: negative noise
      drive(1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 16'd5, 16'd8, 0); step();
      end
      chk("t2_sig",   64'(signal_energy), 64'd256);
      chk("t2_noise", 64'(noise_energy),  64'd36);
      drive(0, 0, 0, 0, 0, 1); step();

      // 3: full-scale samples
      drive(1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 16'd0, 16'hFFFF, 0); step();
      end
      chk("t3_sig",   64'(signal_energy), 64'd17179344900);
      chk("t3_noise", 64'(noise_energy),  64'd17179344900);
      chk("t3_count", 64'(sample_count),  64'd4);

      // 4: stall in HOLD with incoming samples, then continuous restart
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 1, 16'($urandom), 16'($urandom), 0); step();
      end
      chk("t4_lost",  64'(sample_lost),   64'd1);
      chk("t4_sig",   64'(signal_energy), 64'd17179344900);
      chk("t4_rv",    64'(result_valid),  64'd1);
      continuous = 1'b1;
      drive(0, 0, 0, 0, 0, 1); step();
      chk("t4_restart_count", 64'(sample_count),  64'd0);
      chk("t4_restart_busy",  64'(busy),          64'd1);
      chk("t4_restart_rv",    64'(result_valid),  64'd0);
      chk("t4_restart_sig",   64'(signal_energy), 64'd0);

      // 5: abort with start after two samples
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 1, 16'd7, 16'd3, 0); step();
      end
      chk("t5_count2", 64'(sample_count), 64'd2);
      continuous = 1'b0;
      drive(1, 1, 1, 16'd7, 16'd3, 1); step();
      chk("t5_busy",  64'(busy),          64'd0);
      chk("t5_count", 64'(sample_count),  64'd0);
      chk("t5_sig",   64'(signal_energy), 64'd18);
      chk("t5_noise", 64'(noise_energy),  64'd32);
      for (int i = 0; i < 6; i++) begin
         drive(0, 0, 1, 16'd7, 16'd3, 1); step();
         chk("t5_no_rv", 64'(result_valid), 64'd0);
      end

      // 6: asynchronous reset mid-window, then a clean window
      drive(1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 1, 16'd100, 16'd50, 0); step();
      end
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("t6_busy",  64'(busy),          64'd0);
      chk("t6_count", 64'(sample_count),  64'd0);
      chk("t6_sig",   64'(signal_energy), 64'd0);
      chk("t6_noise", 64'(noise_energy),  64'd0);
      chk("t6_rv",    64'(result_valid),  64'd0);
      step();
      reset_n = 1'b1;
      drive(1, 0, 0, 0, 0, 0); step();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 16'd3, 16'd1, 0); step();
      end
      chk("t6_clean_sig",   64'(signal_energy), 64'd4);
      chk("t6_clean_noise", 64'(noise_energy),  64'd16);
      chk("t6_clean_rv",    64'(result_valid),  64'd1);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         start        = (($urandom % 6) == 0);
         abort        = (($urandom % 40) == 0);
         sample_valid = (($urandom % 10) < 7);
         result_ready = (($urandom % 3) == 0);
         if (($urandom % 50) == 0) continuous = ~continuous;
         case ($urandom % 4)
            0:       data_out = 16'd0;
            1:       data_out = 16'hFFFF;
            default: data_out = 16'($urandom);
         endcase
         case ($urandom % 4)
            0:       smoothed_signal = 16'd0;
            1:       smoothed_signal = 16'hFFFF;
            default: smoothed_signal = 16'($urandom);
         endcase
         if (($urandom % 700) == 0) begin
            reset_n = 1'b0;
            model_reset();
            step();
            reset_n = 1'b1;
         end else begin
            step();
         end
      end

      cmp_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
